// File: rtl/cnn_pkg.sv
// Shared CNN geometry: conv layer sizes, derived output side,
// the data word type and the feature-map streamer state encoding.
package cnn_pkg;

    localparam int conv_input_size  = 28;
    localparam int conv_filter_size = 4;
    localparam int conv_num_filters = 16;
    localparam int conv_stride      = 2;
    localparam int conv_out_size    =
        (conv_input_size - conv_filter_size) / conv_stride + 1;

    localparam int data_width = 32;

    typedef logic [data_width-1:0] data_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_STREAM,
        ST_DONE
    } strm_state_e;

endpackage

// File: rtl/conv_fmap_streamer_index_counter.sv
// fmap_index_counter: pixel/filter position of the streamed element.
// Ports: clear_i zeroes, advance_i steps (pixel, wrap -> filter, wrap
// at the end), nxt_*_o show the position after an advance, last_*_o flag
// the last pixel of a map and the last element of the transfer.
module fmap_index_counter #(
    parameter int NF   = 16,
    parameter int NPIX = 169,
    parameter int FW   = $clog2(NF),
    parameter int PW   = $clog2(NPIX)
) (
    input  logic          clk_i,
    input  logic          rstb_i,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [FW-1:0] filter_o,
    output logic [PW-1:0] pixel_o,
    output logic [FW-1:0] nxt_filter_o,
    output logic [PW-1:0] nxt_pixel_o,
    output logic          last_map_o,
    output logic          last_o
);

    logic [FW-1:0] filter_q, filter_d;
    logic [PW-1:0] pixel_q, pixel_d;

    assign last_map_o = (pixel_q == PW'(NPIX - 1));
    assign last_o     = last_map_o && (filter_q == FW'(NF - 1));

    always_comb begin
        pixel_d  = pixel_q + PW'(1);
        filter_d = filter_q;
        if (last_map_o) begin
            pixel_d  = '0;
            filter_d = last_o ? '0 : filter_q + FW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            filter_q <= '0;
            pixel_q  <= '0;
        end else if (clear_i) begin
            filter_q <= '0;
            pixel_q  <= '0;
        end else if (advance_i) begin
            filter_q <= filter_d;
            pixel_q  <= pixel_d;
        end
    end

    assign filter_o     = filter_q;
    assign pixel_o      = pixel_q;
    assign nxt_filter_o = filter_d;
    assign nxt_pixel_o  = pixel_d;

endmodule

// File: rtl/conv_fmap_streamer.sv
// Streams the parallel conv feature maps as a valid/ready word stream,
// filter-major then pixel row-major; start/busy/done frame a transfer.
// Ports: clk, rstb (async low), conv_layer_output array, start, busy,
// m_valid/m_ready/m_data/m_filter_idx/m_pixel_idx/m_last_map/m_last, done.
// Optional macro CONV_FMAP_RELU_EN clamps negative elements to 0 on load.
module conv_fmap_streamer
    import cnn_pkg::*;
#(
    parameter int num_filters = conv_num_filters,
    parameter int out_size    = conv_out_size,
    parameter int data_width  = cnn_pkg::data_width
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic [data_width-1:0] conv_layer_output
                                  [num_filters-1:0][out_size*out_size-1:0],
    input  logic                  start,
    output logic                  busy,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [data_width-1:0] m_data,
    output logic [$clog2(num_filters)-1:0]       m_filter_idx,
    output logic [$clog2(out_size*out_size)-1:0] m_pixel_idx,
    output logic                  m_last_map,
    output logic                  m_last,
    output logic                  done
);

    localparam int NPIX = out_size * out_size;
    localparam int FW   = $clog2(num_filters);
    localparam int PW   = $clog2(NPIX);

    strm_state_e           state_q, state_d;
    logic [data_width-1:0] data_q, data_d;

    logic          cnt_clear, cnt_adv;
    logic [FW-1:0] nxt_f;
    logic [PW-1:0] nxt_p;
    logic          last_map, last;

    function automatic logic [data_width-1:0] load_elem(
        input logic [data_width-1:0] x
    );
`ifdef CONV_FMAP_RELU_EN
        return x[data_width-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    fmap_index_counter #(
        .NF   (num_filters),
        .NPIX (NPIX),
        .FW   (FW),
        .PW   (PW)
    ) u_idx (
        .clk_i        (clk),
        .rstb_i       (rstb),
        .clear_i      (cnt_clear),
        .advance_i    (cnt_adv),
        .filter_o     (m_filter_idx),
        .pixel_o      (m_pixel_idx),
        .nxt_filter_o (nxt_f),
        .nxt_pixel_o  (nxt_p),
        .last_map_o   (last_map),
        .last_o       (last)
    );

    // m_valid is high for the whole STREAM state, so a handshake there is
    // just m_ready; the next element is fetched at the post-advance index.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        cnt_clear = 1'b0;
        cnt_adv   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_STREAM;
                    cnt_clear = 1'b1;
                    data_d    = load_elem(conv_layer_output[0][0]);
                end
            end
            ST_STREAM: begin
                if (m_ready) begin
                    cnt_adv = 1'b1;
                    if (last) begin
                        state_d = ST_DONE;
                    end else begin
                        data_d = load_elem(conv_layer_output[nxt_f][nxt_p]);
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign m_valid    = (state_q == ST_STREAM);
    assign busy       = m_valid;
    assign done       = (state_q == ST_DONE);
    assign m_data     = data_q;
    assign m_last_map = m_valid & last_map;
    assign m_last     = m_valid & last;

endmodule

// File: tb/tb_conv_fmap_streamer.sv
// Directed bench for conv_fmap_streamer: ramp, backpressure, start while
// busy, reset mid-transfer and the ReLU load path.
module tb_conv_fmap_streamer;

    localparam int NF    = 16;
    localparam int NP    = 169;
    localparam int TOTAL = NF * NP;

    logic        clk;
    logic        rstb;
    logic [31:0] fmap [NF-1:0][NP-1:0];
    logic        start;
    logic        busy;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_filter_idx;
    logic [7:0]  m_pixel_idx;
    logic        m_last_map;
    logic        m_last;
    logic        done;

    int checks = 0;
    int errors = 0;

    conv_fmap_streamer dut (
        .clk               (clk),
        .rstb              (rstb),
        .conv_layer_output (fmap),
        .start             (start),
        .busy              (busy),
        .m_valid           (m_valid),
        .m_ready           (m_ready),
        .m_data            (m_data),
        .m_filter_idx      (m_filter_idx),
        .m_pixel_idx       (m_pixel_idx),
        .m_last_map        (m_last_map),
        .m_last            (m_last),
        .done              (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, m_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_data"}, m_data, 0);
        chk({tag, "_fidx"}, m_filter_idx, 0);
        chk({tag, "_pidx"}, m_pixel_idx, 0);
        chk({tag, "_lmap"}, m_last_map, 0);
        chk({tag, "_last"}, m_last, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Entered and left on a negedge; start is raised immediately.
    task automatic xfer(input int pct, input int poke_at,
                        input bit poke_done, input int abort_at);
        int n;
        int cyc;
        int f;
        int p;
        n   = 0;
        cyc = 0;
        start   = 1'b1;
        m_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("lat_valid", m_valid, 1);
        chk("lat_busy", busy, 1);
        while (n < TOTAL && cyc < 20000) begin
            if (n == abort_at) begin
                #2 rstb = 1'b0;
                #1 chk_zero("abort");
                @(negedge clk);
                rstb = 1'b1;
                repeat (3) begin
                    @(negedge clk);
                    chk("abort_nodone", done, 0);
                    chk("abort_idle", m_valid, 0);
                end
                start = 1'b1;
                @(negedge clk);
                start    = 1'b0;
                n        = 0;
                abort_at = -1;
                continue;
            end
            f = n / NP;
            p = n % NP;
            chk($sformatf("valid_%0d", n), m_valid, 1);
            chk($sformatf("busy_%0d", n), busy, 1);
            chk($sformatf("nodone_%0d", n), done, 0);
            chk($sformatf("data_%0d", n), m_data, 64'(f * 1000 + p));
            chk($sformatf("fidx_%0d", n), m_filter_idx, 64'(f));
            chk($sformatf("pidx_%0d", n), m_pixel_idx, 64'(p));
            chk($sformatf("lmap_%0d", n), m_last_map, 64'(p == NP - 1));
            chk($sformatf("last_%0d", n), m_last,
                64'(p == NP - 1 && f == NF - 1));
            m_ready = ($urandom_range(99) < pct);
            start   = (n == poke_at);
            if (m_valid && m_ready) n++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("beats", n, TOTAL);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_valid", m_valid, 0);
        start = poke_done;
        @(negedge clk);
        start = 1'b0;
        chk("done_once", done, 0);
        chk("idle_valid", m_valid, 0);
        chk("idle_busy", busy, 0);
    endtask

    initial begin
        rstb    = 1'b0;
        start   = 1'b0;
        m_ready = 1'b0;
        for (int f = 0; f < NF; f++)
            for (int p = 0; p < NP; p++)
                fmap[f][p] = 32'(f * 1000 + p);
        #3 chk_zero("rst");
        @(negedge clk);
        @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);

        xfer(100, -1, 1'b0, -1);
        xfer(30, -1, 1'b0, -1);
        xfer(100, 50, 1'b1, -1);
        xfer(100, -1, 1'b0, -1);
        xfer(100, -1, 1'b0, 1000);

        fmap[0][0] = 32'hFFFF_FFF6;
        fmap[0][1] = 32'd7;
        m_ready = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
`ifdef CONV_FMAP_RELU_EN
        chk("relu_e0", m_data, 32'h0000_0000);
`else
        chk("relu_e0", m_data, 32'hFFFF_FFF6);
`endif
        @(negedge clk);
        chk("relu_e1", m_data, 32'd7);
        chk("relu_pidx", m_pixel_idx, 1);
        rstb = 1'b0;
        #3;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_fmap_streamer.md
Name: conv_fmap_streamer

Overview:
- Read-side companion to the convolution layer. It walks the parallel conv feature-map array and emits it as a serial 32-bit valid/ready stream, one element per accepted beat.
- Order is filter-major, then pixel (row-major).
- Sits between the conv layer output and the next serial stage (pooling/FC/off-chip writer) inside cnn.
- Turns the wide combinational conv result into a flow-controlled word stream.

Parameters:
- num_filters, 16, number of feature maps.
- out_size, 13, feature-map side: (input_size-filter_size)/stride+1.
- data_width, 32, element width.

Ports:
- clk  input  1  rising-edge clock.
- rstb  input  1  asynchronous active-low reset.
- conv_layer_output  input  [data_width-1:0] x [num_filters-1:0][out_size*out_size-1:0]  unpacked feature-map array; held stable by upstream while busy=1.
- start  input  1  one-cycle request to stream the current maps.
- busy  output  1  high from the cycle after an accepted start until done.
- m_valid  output  1  stream element valid.
- m_ready  input  1  downstream accept.
- m_data  output  data_width  element value (registered).
- m_filter_idx  output  $clog2(num_filters)  filter index of m_data.
- m_pixel_idx  output  $clog2(out_size*out_size)  pixel index of m_data.
- m_last_map  output  1  last pixel of the current filter map.
- m_last  output  1  final element of the whole transfer.
- done  output  1  one-cycle pulse after the final handshake.

Behaviour:
- Reset (async, rstb=0): state=IDLE; busy, m_valid, m_last_map, m_last and done are 0; m_data, m_filter_idx and m_pixel_idx are 0.
- FSM states: IDLE, STREAM, DONE.
- IDLE:
  - start=1 -> STREAM.
  - Next cycle: m_valid=1, m_data=conv_layer_output[0][0], indices 0, busy=1.
  - Latency from start to first valid is 1 cycle.
- STREAM:
  - A handshake occurs on m_valid & m_ready.
  - While m_ready=0, every m_* output holds unchanged (no drop, no change).
  - On a handshake of a non-final element, the next element is loaded the following cycle with m_valid kept high, so there is no bubble. Full throughput is 1 element per cycle.
  - Index advance: pixel increments. At out_size*out_size-1 the pixel wraps to 0 and the filter increments.
  - m_last_map=1 when pixel==out_size^2-1.
  - m_last=1 when additionally filter==num_filters-1.
  - On the m_last handshake -> DONE. m_valid drops next cycle.
- DONE: done=1 for exactly one cycle, busy=0 in that cycle -> IDLE.
- Total beats per transfer: num_filters*out_size^2 (2704 at defaults).
- start is ignored while in STREAM or DONE; there is no queueing. start in the same cycle as the DONE pulse is also ignored. A new start is honoured only in IDLE.
- Reset mid-transfer aborts immediately. No done is produced; the next start restarts at [0][0].
- Upstream changing conv_layer_output while busy is a protocol violation; the block samples the array only when loading m_data.
- No arithmetic on data except the optional feature below.

Optional Feature:
- Macro: CONV_FMAP_RELU_EN.
- Defined: each element is treated as signed two's complement when loaded into m_data. If bit [data_width-1]=1, m_data is loaded with 0; otherwise the value passes through.
- Undefined: m_data is the raw element, bit-exact.
- Timing, indices and handshake are identical in both builds.

Decomposition:
- Shared package cnn_pkg: conv_filter_size, conv_num_filters, conv_stride, derived conv_out_size, and a typedef for the 32-bit data word. These are shared with cnn and conv_layer.
- One natural sub-module, fmap_index_counter: pixel/filter counters with advance, wrap and last-flag generation. The FSM and data mux stay in the top.

Test Plan:
- Ramp fill: element[f][p]=f*1000+p; start with m_ready tied 1.
  - m_valid rises 1 cycle after start.
  - 2704 consecutive beats, values match the ramp in order.
  - m_last_map on p=168 for each f.
  - m_last only on f=15,p=168.
  - done pulses exactly once, 1 cycle after the last beat.
- Backpressure: m_ready random at 30% duty.
  - m_data and indices are stable across every stall.
  - Every value is delivered exactly once, in order.
  - Still 2704 handshakes total.
- Start while busy: pulse start at beat 50 and on the DONE cycle.
  - No restart, no extra transfer.
  - A start 1 cycle after DONE gives a fresh transfer from [0][0].
- Reset mid-transfer: assert rstb=0 at beat 1000.
  - All outputs are 0 asynchronously.
  - No done pulse.
  - The following start re-emits from element [0][0]=0.
- CONV_FMAP_RELU_EN: element[0][0]=32'hFFFF_FFF6 (-10), element[0][1]=32'd7.
  - Defined build: m_data outputs 0 then 7.
  - Undefined build: m_data outputs 32'hFFFF_FFF6 then 7.
